// File: rtl/vend_pkg.sv
// Shared vending types: coin encodings, FSM states and coin values.
// Also used by the other vending machine blocks for coin decoding.
package vend_pkg;

    localparam logic [2:0] COIN_NONE = 3'b000;
    localparam logic [2:0] COIN_1    = 3'b001;
    localparam logic [2:0] COIN_2    = 3'b010;
    localparam logic [2:0] COIN_5    = 3'b101;

    typedef enum logic [1:0] {
        S_COLLECT = 2'd0,
        S_VEND    = 2'd1,
        S_PAYOUT  = 2'd2
    } vend_state_e;

    // Rupee value of a coin code; 0 for "none" and for illegal codes.
    function automatic logic [3:0] coin_value(input logic [2:0] code);
        logic [3:0] v;
        case (code)
            COIN_1:  v = 4'd1;
            COIN_2:  v = 4'd2;
            COIN_5:  v = 4'd5;
            default: v = 4'd0;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/vend_if.sv
// Vending controller bus: coin input, motor and hopper handshakes, status.
// master = machine side (drives coin/cancel/acks), slave = controller.
interface vend_if;
    import vend_pkg::*;

    logic [2:0] coin;
    logic       cancel;
    logic       motor_req;
    logic       motor_done;
    logic       pay_req;
    logic [2:0] pay_coin;
    logic       pay_ack;
    logic [3:0] credit;
    logic       busy;
    logic       coin_reject;
    logic       fault;
    logic [7:0] vend_count;

    modport master (
        output coin, cancel, motor_done, pay_ack,
        input  motor_req, pay_req, pay_coin, credit,
        input  busy, coin_reject, fault, vend_count
    );

    modport slave (
        input  coin, cancel, motor_done, pay_ack,
        output motor_req, pay_req, pay_coin, credit,
        output busy, coin_reject, fault, vend_count
    );

endinterface

// File: rtl/vend_change_select.sv
// Greedy change denomination: largest of 5/2/1 not above credit.
// Ports: credit (rupees) in, pay_coin (coin code, 000 when credit=0) out.
module vend_change_select
    import vend_pkg::*;
(
    input  logic [3:0] credit,
    output logic [2:0] pay_coin
);

    always_comb begin
        pay_coin = COIN_NONE;
        if (credit >= 4'd5) begin
            pay_coin = COIN_5;
        end else if (credit >= 4'd2) begin
            pay_coin = COIN_2;
        end else if (credit >= 4'd1) begin
            pay_coin = COIN_1;
        end
    end

endmodule

// File: rtl/vend_controller.sv
// Vending controller FSM: collects coins, runs the motor, pays change.
// Ports: clk, reset (sync, active-high), bus (vend_if.slave).
module vend_controller
    import vend_pkg::*;
#(
    parameter int PRICE         = 7,
    parameter int MOTOR_TIMEOUT = 32
) (
    input  logic   clk,
    input  logic   reset,
    vend_if.slave  bus
);

    localparam logic [1:0] COLLECT = S_COLLECT;
    localparam logic [1:0] VEND    = S_VEND;
    localparam logic [1:0] PAYOUT  = S_PAYOUT;

    localparam int         TW      = $clog2(MOTOR_TIMEOUT + 1);
    localparam logic [3:0] PRICE4  = 4'(PRICE);
    localparam logic [TW-1:0] TLAST = TW'(MOTOR_TIMEOUT - 1);

    logic [1:0]    state,       state_n;
    logic [3:0]    credit,      credit_n;
    logic [7:0]    vend_count,  count_n;
    logic [TW-1:0] tmr,         tmr_n;
    logic          motor_req;
    logic          pay_req;
    logic [2:0]    pay_coin,    pay_coin_n;
    logic          coin_reject, reject_n;
    logic          fault,       fault_n;
    logic [3:0]    coin_val;
    logic [3:0]    sum;
    logic [3:0]    remain;

    assign coin_val = coin_value(bus.coin);
    assign sum      = credit + coin_val;
    assign remain   = credit - PRICE4;

    // Denomination follows the credit the FSM will hold next cycle,
    // so pay_coin is registered alongside pay_req.
    vend_change_select u_sel (
        .credit   (credit_n),
        .pay_coin (pay_coin_n)
    );

    always_comb begin
        state_n  = state;
        credit_n = credit;
        count_n  = vend_count;
        tmr_n    = tmr;
        reject_n = 1'b0;
        fault_n  = 1'b0;
        case (state)
            COLLECT: begin
                tmr_n = '0;
                // A taken cancel wins over a coin in the same cycle.
                if (bus.cancel && credit != 4'd0) begin
                    reject_n = (bus.coin != COIN_NONE);
                    state_n  = PAYOUT;
                end else if (bus.coin != COIN_NONE) begin
                    if (coin_val == 4'd0) begin
                        reject_n = 1'b1;
                    end else begin
                        credit_n = sum;
                        if (sum >= PRICE4) begin
                            state_n = VEND;
                        end
                    end
                end
            end
            VEND: begin
                reject_n = (bus.coin != COIN_NONE);
                if (bus.motor_done) begin
                    credit_n = remain;
                    count_n  = vend_count + 8'd1;
                    state_n  = (remain != 4'd0) ? PAYOUT : COLLECT;
                end else if (tmr == TLAST) begin
                    // Timed out: refund everything, no vend counted.
                    fault_n = 1'b1;
                    state_n = PAYOUT;
                end else begin
                    tmr_n = tmr + TW'(1);
                end
            end
            PAYOUT: begin
                reject_n = (bus.coin != COIN_NONE);
                if (bus.pay_ack) begin
                    credit_n = credit - coin_value(pay_coin);
                    if (credit_n == 4'd0) begin
                        state_n = COLLECT;
                    end
                end
            end
            default: begin
                state_n = COLLECT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= COLLECT;
            credit      <= 4'd0;
            vend_count  <= 8'd0;
            tmr         <= '0;
            motor_req   <= 1'b0;
            pay_req     <= 1'b0;
            pay_coin    <= COIN_NONE;
            coin_reject <= 1'b0;
            fault       <= 1'b0;
        end else begin
            state       <= state_n;
            credit      <= credit_n;
            vend_count  <= count_n;
            tmr         <= tmr_n;
            motor_req   <= (state_n == VEND);
            pay_req     <= (state_n == PAYOUT);
            pay_coin    <= (state_n == PAYOUT) ? pay_coin_n : COIN_NONE;
            coin_reject <= reject_n;
            fault       <= fault_n;
        end
    end

    assign bus.motor_req   = motor_req;
    assign bus.pay_req     = pay_req;
    assign bus.pay_coin    = pay_coin;
    assign bus.credit      = credit;
    assign bus.busy        = (state != COLLECT);
    assign bus.coin_reject = coin_reject;
    assign bus.fault       = fault;
    assign bus.vend_count  = vend_count;

endmodule

// File: tb/tb_vend_controller.sv
// Self-checking bench for vend_controller: directed scenarios plus
// random traffic compared every cycle against a behavioural model.
module tb_vend_controller;

    localparam int PRICE = 7;
    localparam int TMO   = 32;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    vend_if bus ();

    vend_controller #(.PRICE(PRICE), .MOTOR_TIMEOUT(TMO)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    // Reference model: phase 0 = taking coins, 1 = motor, 2 = giving change
    int m_phase, m_credit, m_count, m_elapsed;
    bit m_rej, m_fault;

    function automatic int rupees(input logic [2:0] c);
        if (c == 3'b001) return 1;
        if (c == 3'b010) return 2;
        if (c == 3'b101) return 5;
        return 0;
    endfunction

    function automatic int greedy(input int c);
        if (c >= 5) return 5;
        if (c >= 2) return 2;
        if (c >= 1) return 1;
        return 0;
    endfunction

    function automatic logic [2:0] code_of(input int v);
        if (v == 5) return 3'b101;
        if (v == 2) return 3'b010;
        if (v == 1) return 3'b001;
        return 3'b000;
    endfunction

    task automatic model(input logic [2:0] c, input logic cn,
                         input logic md, input logic pa, input logic rs);
        m_rej   = 0;
        m_fault = 0;
        if (rs) begin
            m_phase = 0; m_credit = 0; m_count = 0; m_elapsed = 0;
        end else if (m_phase == 0) begin
            if (cn && m_credit > 0) begin
                m_rej   = (c != 3'b000);
                m_phase = 2;
            end else if (c != 3'b000) begin
                if (rupees(c) == 0) begin
                    m_rej = 1;
                end else begin
                    m_credit += rupees(c);
                    if (m_credit >= PRICE) begin
                        m_phase   = 1;
                        m_elapsed = 0;
                    end
                end
            end
        end else if (m_phase == 1) begin
            m_rej = (c != 3'b000);
            if (md) begin
                m_credit -= PRICE;
                m_count   = (m_count + 1) % 256;
                m_phase   = (m_credit > 0) ? 2 : 0;
            end else begin
                m_elapsed++;
                if (m_elapsed >= TMO) begin
                    m_fault = 1;
                    m_phase = 2;
                end
            end
        end else begin
            m_rej = (c != 3'b000);
            if (pa) begin
                m_credit -= greedy(m_credit);
                if (m_credit == 0) m_phase = 0;
            end
        end
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic compare_all();
        chk("credit",      int'(bus.credit),      m_credit);
        chk("vend_count",  int'(bus.vend_count),  m_count);
        chk("motor_req",   int'(bus.motor_req),   int'(m_phase == 1));
        chk("pay_req",     int'(bus.pay_req),     int'(m_phase == 2));
        chk("pay_coin",    int'(bus.pay_coin),
            (m_phase == 2) ? int'(code_of(greedy(m_credit))) : 0);
        chk("busy",        int'(bus.busy),        int'(m_phase != 0));
        chk("coin_reject", int'(bus.coin_reject), int'(m_rej));
        chk("fault",       int'(bus.fault),       int'(m_fault));
        chk("exclusive",   int'(bus.motor_req & bus.pay_req), 0);
    endtask

    task automatic cyc(input logic [2:0] c, input logic cn,
                       input logic md, input logic pa, input logic rs);
        bus.coin       = c;
        bus.cancel     = cn;
        bus.motor_done = md;
        bus.pay_ack    = pa;
        reset          = rs;
        @(posedge clk);
        model(c, cn, md, pa, rs);
        #1;
        compare_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(3'b000, 0, 0, 0, 0);
    endtask

    // Acknowledge payouts until back in COLLECT, bounded.
    task automatic drain(input string tag);
        int n;
        n = 0;
        while (bus.pay_req && n < 20) begin
            cyc(3'b000, 0, 0, 1, 0);
            n++;
        end
        chk({tag, "_drained"}, int'(bus.pay_req), 0);
    endtask

    int mcnt;
    int fault_at;

    initial begin
        m_phase = 0; m_credit = 0; m_count = 0; m_elapsed = 0;
        cyc(3'b000, 0, 0, 0, 1);
        cyc(3'b000, 0, 0, 0, 1);
        chk("rst_credit", int'(bus.credit), 0);
        chk("rst_busy",   int'(bus.busy),   0);

        // Exact pay: 2 + 5, motor_done on third VEND cycle
        cyc(3'b010, 0, 0, 0, 0);
        cyc(3'b101, 0, 0, 0, 0);
        mcnt = 0;
        for (int i = 0; i < 3; i++) begin
            mcnt += int'(bus.motor_req);
            cyc(3'b000, 0, (i == 2), 0, 0);
        end
        chk("exact_motor_cycles", mcnt, 3);
        chk("exact_credit",  int'(bus.credit),     0);
        chk("exact_count",   int'(bus.vend_count), 1);
        chk("exact_no_pay",  int'(bus.pay_req),    0);

        // Overpay: 5 + 5 = 10, change 2 then 1
        cyc(3'b101, 0, 0, 0, 0);
        cyc(3'b101, 0, 0, 0, 0);
        cyc(3'b000, 0, 1, 0, 0);
        chk("over_coin2", int'(bus.pay_coin), 3'b010);
        idle(2);
        cyc(3'b000, 0, 0, 1, 0);
        chk("over_coin1", int'(bus.pay_coin), 3'b001);
        cyc(3'b000, 0, 0, 1, 0);
        chk("over_done", int'(bus.busy), 0);

        // Cancel: 5 + 1, refund 5 then 1, stray 2 refused
        cyc(3'b101, 0, 0, 0, 0);
        cyc(3'b001, 0, 0, 0, 0);
        cyc(3'b000, 1, 0, 0, 0);
        chk("cancel_coin5", int'(bus.pay_coin), 3'b101);
        cyc(3'b010, 0, 0, 0, 0);
        chk("cancel_rej", int'(bus.coin_reject), 1);
        chk("cancel_cred", int'(bus.credit), 6);
        drain("cancel");
        chk("cancel_count", int'(bus.vend_count), 2);

        // Timeout: 2 + 5, no motor_done
        cyc(3'b010, 0, 0, 0, 0);
        cyc(3'b101, 0, 0, 0, 0);
        fault_at = 0;
        for (int i = 1; i <= TMO + 2 && fault_at == 0; i++) begin
            cyc(3'b000, 0, 0, 0, 0);
            if (bus.fault) fault_at = i;
        end
        chk("tmo_cycles", fault_at, TMO);
        chk("tmo_refund5", int'(bus.pay_coin), 3'b101);
        drain("tmo");
        chk("tmo_count", int'(bus.vend_count), 2);

        // Illegal code, cancel at zero credit, coin+cancel
        cyc(3'b011, 0, 0, 0, 0);
        chk("illegal_rej", int'(bus.coin_reject), 1);
        cyc(3'b000, 1, 0, 0, 0);
        chk("cancel_zero", int'(bus.busy), 0);
        cyc(3'b010, 0, 0, 0, 0);
        cyc(3'b101, 1, 0, 0, 0);
        chk("coin_cancel_cred", int'(bus.credit), 2);

        // pay_ack held continuously: one denomination per cycle
        cyc(3'b000, 0, 0, 1, 0);
        chk("ackhold_empty", int'(bus.credit), 0);
        cyc(3'b101, 0, 0, 0, 0);
        cyc(3'b101, 0, 0, 0, 0);
        cyc(3'b000, 0, 1, 1, 0);
        cyc(3'b000, 0, 0, 1, 0);
        chk("ackhold_mid", int'(bus.credit), 1);
        cyc(3'b000, 0, 0, 1, 0);
        chk("ackhold_end", int'(bus.busy), 0);

        // Reset mid-PAYOUT with credit 3
        cyc(3'b010, 0, 0, 0, 0);
        cyc(3'b001, 0, 0, 0, 0);
        cyc(3'b000, 1, 0, 0, 0);
        chk("rstpay_cred", int'(bus.credit), 3);
        cyc(3'b000, 0, 0, 0, 1);
        chk("rstpay_credit", int'(bus.credit), 0);
        chk("rstpay_payreq", int'(bus.pay_req), 0);

        // Random traffic
        for (int i = 0; i < 2000; i++) begin
            logic [2:0] c;
            c = ($urandom_range(0, 2) == 0) ? 3'($urandom) : 3'b000;
            cyc(c, ($urandom_range(0, 9) == 0),
                ($urandom_range(0, 3) == 0),
                ($urandom_range(0, 1) == 0),
                ($urandom_range(0, 199) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
